// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: opcodes, flag bit positions,
// FSM states and the decoded-instruction record.
package wb_pkg;

    localparam logic [4:0] OP_NOP       = 5'h00;
    localparam logic [4:0] OP_ALU_FIRST = 5'h01;
    localparam logic [4:0] OP_ALU_LAST  = 5'h0B;
    localparam logic [4:0] OP_MUL       = 5'h0C;
    localparam logic [4:0] OP_LOAD      = 5'h0D;
    localparam logic [4:0] OP_STORE     = 5'h0E;
    localparam logic [4:0] OP_JMP       = 5'h0F;
    localparam logic [4:0] OP_JZ        = 5'h10;
    localparam logic [4:0] OP_JC        = 5'h11;
    localparam logic [4:0] OP_HLT       = 5'h1F;

    localparam int FLG_Z  = 0;
    localparam int FLG_C  = 1;
    localparam int FLG_AC = 2;
    localparam int FLG_P  = 3;

    typedef enum logic [1:0] {S_RUN, S_MUL_HI, S_LOAD, S_HALT} wb_state_t;

    typedef enum logic [1:0] {BR_NONE, BR_JMP, BR_JZ, BR_JC} br_t;

    typedef struct packed {
        logic rf_wr;
        logic mul;
        logic load;
        logic store;
        logic flag_upd;
        br_t  br;
        logic halt;
    } dec_t;

endpackage

// File: rtl/wb_if.sv
// EX/WB latch interface: the EX side drives the instruction fields, the
// write-back stage answers with in_ready.
interface wb_if #(
    parameter int DW   = 8,
    parameter int DMAW = 4,
    parameter int IMAW = 6,
    parameter int RAW  = 3
);
    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // fields are only meaningful while in_valid is high, and in_ready never
    // depends on in_valid.
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        opcode;
    logic              am;
    logic [RAW-1:0]    rd;
    logic [DMAW-1:0]   mem_addr;
    logic [IMAW-1:0]   instr_mem_addr;
    logic [2*DW-1:0]   result;
    logic              zero_flag;
    logic              carry_flag;
    logic              ac_flag;
    logic              parity_flag;

    modport master (
        output in_valid, opcode, am, rd, mem_addr, instr_mem_addr, result,
               zero_flag, carry_flag, ac_flag, parity_flag,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, am, rd, mem_addr, instr_mem_addr, result,
               zero_flag, carry_flag, ac_flag, parity_flag,
        output in_ready
    );

endinterface

// File: rtl/wb_decode.sv
// Combinational opcode decode into the enables the write-back FSM acts on.
module wb_decode
    import wb_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       am,
    output dec_t       dec
);

    always_comb begin
        dec    = '0;
        dec.br = BR_NONE;
        if (opcode >= OP_ALU_FIRST && opcode <= OP_ALU_LAST) begin
            // am=1 is the compare form: flags only
            dec.flag_upd = 1'b1;
            dec.rf_wr    = !am;
        end else begin
            case (opcode)
                OP_MUL: begin
                    dec.mul      = 1'b1;
                    dec.flag_upd = 1'b1;
                end
                OP_LOAD:  dec.load  = 1'b1;
                OP_STORE: dec.store = 1'b1;
                OP_JMP:   dec.br    = BR_JMP;
                OP_JZ:    dec.br    = BR_JZ;
                OP_JC:    dec.br    = BR_JC;
                OP_HLT:   dec.halt  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires EX/WB instructions into the register file, data
// memory, flags and PC. Optional retired-instruction counter: WB_RETIRE_CNT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 8,
    parameter int DMAW = 4,
    parameter int IMAW = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_if.slave                      ex,
    output logic                     rf_we,
    output logic [$clog2(NREG)-1:0]  rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    output logic                     dm_we,
    output logic                     dm_re,
    output logic [DMAW-1:0]          dm_addr,
    output logic [DW-1:0]            dm_wdata,
    input  logic [DW-1:0]            dm_rdata,
    output logic [3:0]               flags_q,
    output logic                     pc_load,
    output logic [IMAW-1:0]          pc_target,
    output logic                     halted,
    output wb_state_t                fsm_state
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [15:0]              retired_cnt
`endif
);

    localparam int RAW = $clog2(NREG);

    wb_state_t       state;
    dec_t            dec;
    logic            fire;
    logic            br_taken;
    logic [DW-1:0]   hi_q;
    logic [RAW-1:0]  pend_rd;

    wb_decode u_decode (
        .opcode (ex.opcode),
        .am     (ex.am),
        .dec    (dec)
    );

    assign ex.in_ready = (state == S_RUN);
    assign fire        = ex.in_valid && ex.in_ready;
    assign fsm_state   = state;

    // Conditional jumps test the flags as they stood before this instruction
    assign br_taken = (dec.br == BR_JMP)
                   || (dec.br == BR_JZ && flags_q[FLG_Z])
                   || (dec.br == BR_JC && flags_q[FLG_C]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            dm_we     <= 1'b0;
            dm_re     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            flags_q   <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            halted    <= 1'b0;
            hi_q      <= '0;
            pend_rd   <= '0;
`ifdef WB_RETIRE_CNT_EN
            retired_cnt <= '0;
`endif
        end else begin
            rf_we   <= 1'b0;
            dm_we   <= 1'b0;
            dm_re   <= 1'b0;
            pc_load <= 1'b0;
            case (state)
                S_RUN: begin
                    if (fire) begin
                        if (dec.flag_upd) begin
                            flags_q[FLG_Z]  <= ex.zero_flag;
                            flags_q[FLG_C]  <= ex.carry_flag;
                            flags_q[FLG_AC] <= ex.ac_flag;
                            flags_q[FLG_P]  <= ex.parity_flag;
                        end
                        if (dec.rf_wr || dec.mul) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= ex.rd;
                            rf_wdata <= ex.result[DW-1:0];
                        end
                        if (dec.mul) begin
                            // high byte goes to the next register, wrapping past NREG-1
                            hi_q    <= ex.result[2*DW-1:DW];
                            pend_rd <= ex.rd + 1'b1;
                            state   <= S_MUL_HI;
                        end
                        if (dec.load) begin
                            dm_re   <= 1'b1;
                            dm_addr <= ex.mem_addr;
                            pend_rd <= ex.rd;
                            state   <= S_LOAD;
                        end
                        if (dec.store) begin
                            dm_we    <= 1'b1;
                            dm_addr  <= ex.mem_addr;
                            dm_wdata <= ex.result[DW-1:0];
                        end
                        if (br_taken) begin
                            pc_load   <= 1'b1;
                            pc_target <= ex.instr_mem_addr;
                        end
                        if (dec.halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
`ifdef WB_RETIRE_CNT_EN
                        if (dec.flag_upd || dec.load || dec.store
                            || dec.br != BR_NONE || dec.halt) begin
                            retired_cnt <= retired_cnt + 16'd1;
                        end
`endif
                    end
                end
                S_MUL_HI: begin
                    rf_we    <= 1'b1;
                    rf_waddr <= pend_rd;
                    rf_wdata <= hi_q;
                    state    <= S_RUN;
                end
                S_LOAD: begin
                    // memory read is asynchronous, so dm_rdata is valid this cycle
                    rf_we    <= 1'b1;
                    rf_waddr <= pend_rd;
                    rf_wdata <= dm_rdata;
                    state    <= S_RUN;
                end
                default: ;
            endcase
        end
    end

endmodule
